wb_arbiter2: RTL and testbench
==============================

WB_ARBITER2 -- requirements
Module: wb_arbiter2

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: slave cycles without ack before the arbiter terminates the access with err.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous assertion, active-low.
REQ-004 SHALL have port wb_m0  wshb_if.slave  bundle  requester 0 (higher-index tie loser only by fairness rule).
REQ-005 SHALL have port wb_m1  wshb_if.slave  bundle  requester 1.
REQ-006 SHALL have port wb_s  wshb_if.master  bundle  shared target (32-bit Wishbone BRAM, byte-lane sel, cti/bte bursts).

Function
REQ-007 SHALL implement FSM states IDLE, GNT0, GNT1; reset state IDLE.
REQ-008 IDLE: cyc from one master -> grant it next cycle; both -> grant the master not in register last_gnt.
REQ-009 GNTx: stay while wb_mx.cyc=1; on cyc=0 -> GNTy if wb_my.cyc=1, else IDLE; last_gnt<=x on leaving GNTx.
REQ-010 Grant SHALL never change while granted cyc=1, including cti=010 incrementing bursts until master drops cyc after cti=111.
REQ-011 In GNTx: wb_s.cyc/stb/we/adr/sel/dat_ms/cti/bte SHALL combinationally equal wb_mx fields; wb_mx.ack/dat_sm/err/rty SHALL equal wb_s fields.
REQ-012 In IDLE: wb_s.cyc=0, stb=0, we=0, other wb_s outputs 0.
REQ-013 Non-granted master SHALL see ack=0, err=0, rty=0, dat_sm=0.
REQ-014 Arbitration latency: first granted wb_s.stb one cycle after master cyc/stb rise from IDLE; handover GNTx->GNTy zero idle cycles.
REQ-015 Watchdog: 8-bit counter, cleared when wb_s.ack=1, wb_s.stb=0, or grant changes; increments each cycle wb_s.stb=1 and ack=0.
REQ-016 Counter = TIMEOUT-1 and no ack SHALL pulse wb_mx.err for one cycle, force wb_s.stb=0 in that cycle, clear counter.
REQ-017 Simultaneous slave ack and watchdog expiry: ack wins, no err.
REQ-018 Write acks (combinational in the target) and read acks (one-cycle registered) both pass through unchanged; no buffering, no extra latency.
REQ-019 TIMEOUT SHALL be 2..255; outside range is an elaboration error.

Reset
REQ-020 rst=0 SHALL immediately force state=IDLE, last_gnt=1, counter=0, all wb_s outputs 0, all master ack/err/rty 0.
REQ-021 Reset asserted mid-burst SHALL abort the transfer with no ack/err to either master; first grant after release obeys REQ-008 with last_gnt=1.
REQ-022 Release of rst SHALL be synchronised by the instantiating top; block assumes clean deassertion.

Structure
REQ-023 Shared package wb_arb_pkg SHALL hold the state enum type (IDLE, GNT0, GNT1) and cti constants CTI_CLASSIC=000, CTI_INCR=010, CTI_END=111.
REQ-024 Watchdog SHALL be one sub-module wb_watchdog (ports clk, rst, run, clear, expire; parameter TIMEOUT); the mux stays in the top.
REQ-025 Target RTL size 150-250 lines total.

Verification
REQ-026 After reset, m0 alone writes 0xDEADBEEF to adr 0x10, sel=1111 -> one wb_s write, m0 ack one cycle, read-back 0xDEADBEEF, m1 ack stays 0.
REQ-027 m0 and m1 raise cyc in the same cycle from reset -> GNT0 first; after m0 drops cyc, GNT1 in the next cycle; repeat collision -> GNT0 again (round robin alternates).
REQ-028 m0 4-beat cti=010 bte=00 read from adr 0x20 while m1 requests at beat 2 -> 4 consecutive m0 acks, no m1 ack until m0 cyc=0 after cti=111.
REQ-029 Target model stalls ack, TIMEOUT=16 -> err on granted master exactly 16 cycles after stb rise, wb_s.stb=0 that cycle, ack never seen.
REQ-030 rst pulled low during beat 2 of a m1 burst -> wb_s.cyc=0 in same cycle (async); after release, simultaneous requests -> m0 granted.
REQ-031 m0 byte write sel=0100 data 0x00AB0000 to adr 0x30 over prior 0x11223344 -> m1 reads 0x11AB3344.

Source files
------------

// File: rtl/wb_arbiter2_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

endpackage

// File: rtl/wb_arbiter2_if.sv
// 32-bit Wishbone bundle; master drives the request, slave drives the response.
interface wshb_if;

  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [31:0] dat_ms;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack;
  logic [31:0] dat_sm;
  logic        err;
  logic        rty;

  modport master (
    output cyc, stb, we, adr, sel, dat_ms, cti, bte,
    input  ack, dat_sm, err, rty
  );

  modport slave (
    input  cyc, stb, we, adr, sel, dat_ms, cti, bte,
    output ack, dat_sm, err, rty
  );

endinterface

// File: rtl/wb_arbiter2_watchdog.sv
// Stalled-access watchdog: counts unacknowledged strobe cycles and flags
// expiry on the cycle the count reaches TIMEOUT-1.
module wb_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic expire
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // run already excludes ack, so a coincident ack suppresses expiry
  assign expire = run && (cnt_q == LAST);

  // next count: clear/expire restart from zero, otherwise count stalled cycles
  always_comb begin
    cnt_d = cnt_q;
    if (clear || expire) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_arbiter2.sv
// Two-master Wishbone arbiter with round-robin tie break, cycle-locked grant
// and a watchdog that terminates stalled accesses with err.
module wb_arbiter2
  import wb_arb_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic   clk,
  input  logic   rst,
  wshb_if.slave  wb_m0,
  wshb_if.slave  wb_m1,
  wshb_if.master wb_s
);

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("wb_arbiter2: TIMEOUT must be within 2..255");
  end

  arb_state_e state_q;
  arb_state_e state_d;
  logic       last_gnt_q;
  logic       last_gnt_d;
  logic       gnt_stb;
  logic       wd_run;
  logic       wd_clear;
  logic       expire;

  // next grant: hold while the owner keeps cyc, hand over directly on release
  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    case (state_q)
      IDLE: begin
        if (wb_m0.cyc && wb_m1.cyc) begin
          state_d = last_gnt_q ? GNT0 : GNT1;
        end else if (wb_m0.cyc) begin
          state_d = GNT0;
        end else if (wb_m1.cyc) begin
          state_d = GNT1;
        end
      end
      GNT0: begin
        if (!wb_m0.cyc) begin
          last_gnt_d = 1'b0;
          state_d    = wb_m1.cyc ? GNT1 : IDLE;
        end
      end
      GNT1: begin
        if (!wb_m1.cyc) begin
          last_gnt_d = 1'b1;
          state_d    = wb_m0.cyc ? GNT0 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // grant state and round-robin history
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  // watchdog sees the owner's raw strobe so the forced-low stb cannot loop back
  assign gnt_stb  = (state_q == GNT0) ? wb_m0.stb :
                    (state_q == GNT1) ? wb_m1.stb : 1'b0;
  assign wd_run   = gnt_stb && !wb_s.ack;
  assign wd_clear = !gnt_stb || wb_s.ack || (state_d != state_q);

  wb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk   (clk),
    .rst   (rst),
    .run   (wd_run),
    .clear (wd_clear),
    .expire(expire)
  );

  // bus mux: owner routed straight through, everything else held at zero
  always_comb begin
    wb_s.cyc     = 1'b0;
    wb_s.stb     = 1'b0;
    wb_s.we      = 1'b0;
    wb_s.adr     = '0;
    wb_s.sel     = '0;
    wb_s.dat_ms  = '0;
    wb_s.cti     = '0;
    wb_s.bte     = '0;
    wb_m0.ack    = 1'b0;
    wb_m0.dat_sm = '0;
    wb_m0.err    = 1'b0;
    wb_m0.rty    = 1'b0;
    wb_m1.ack    = 1'b0;
    wb_m1.dat_sm = '0;
    wb_m1.err    = 1'b0;
    wb_m1.rty    = 1'b0;
    case (state_q)
      GNT0: begin
        wb_s.cyc     = wb_m0.cyc;
        wb_s.stb     = wb_m0.stb && !expire;
        wb_s.we      = wb_m0.we;
        wb_s.adr     = wb_m0.adr;
        wb_s.sel     = wb_m0.sel;
        wb_s.dat_ms  = wb_m0.dat_ms;
        wb_s.cti     = wb_m0.cti;
        wb_s.bte     = wb_m0.bte;
        wb_m0.ack    = wb_s.ack;
        wb_m0.dat_sm = wb_s.dat_sm;
        wb_m0.err    = wb_s.err || expire;
        wb_m0.rty    = wb_s.rty;
      end
      GNT1: begin
        wb_s.cyc     = wb_m1.cyc;
        wb_s.stb     = wb_m1.stb && !expire;
        wb_s.we      = wb_m1.we;
        wb_s.adr     = wb_m1.adr;
        wb_s.sel     = wb_m1.sel;
        wb_s.dat_ms  = wb_m1.dat_ms;
        wb_s.cti     = wb_m1.cti;
        wb_s.bte     = wb_m1.bte;
        wb_m1.ack    = wb_s.ack;
        wb_m1.dat_sm = wb_s.dat_sm;
        wb_m1.err    = wb_s.err || expire;
        wb_m1.rty    = wb_s.rty;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed bench for wb_arbiter2 with a small BRAM target model.
module tb_wb_arbiter2;
  import wb_arb_pkg::*;

  logic clk;
  logic rst;

  wshb_if m0_if ();
  wshb_if m1_if ();
  wshb_if s_if ();

  wb_arbiter2 #(.TIMEOUT(16)) dut (
    .clk  (clk),
    .rst  (rst),
    .wb_m0(m0_if),
    .wb_m1(m1_if),
    .wb_s (s_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- target model ----------------
  logic [31:0] mem [0:63];
  logic [7:0]  wdelay;
  logic [7:0]  wcnt;
  logic        rd_ack_q;
  logic [31:0] rd_dat_q;
  int          n_swr;

  assign s_if.ack    = (s_if.cyc && s_if.stb && s_if.we && (wcnt >= wdelay)) || rd_ack_q;
  assign s_if.dat_sm = rd_dat_q;
  assign s_if.err    = 1'b0;
  assign s_if.rty    = 1'b0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ack_q <= 1'b0;
      rd_dat_q <= '0;
      wcnt     <= '0;
    end else begin
      rd_ack_q <= s_if.cyc && s_if.stb && !s_if.we && (!rd_ack_q || s_if.cti == CTI_INCR);
      if (s_if.cyc && s_if.stb && !s_if.we)
        rd_dat_q <= mem[s_if.adr[7:2] + ((rd_ack_q && s_if.cti == CTI_INCR) ? 6'd1 : 6'd0)];
      wcnt <= (s_if.cyc && s_if.stb && !s_if.ack) ? wcnt + 8'd1 : 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (s_if.cyc && s_if.stb && s_if.we && s_if.ack) begin
      n_swr <= n_swr + 1;
      for (int b = 0; b < 4; b++)
        if (s_if.sel[b]) mem[s_if.adr[7:2]][8*b +: 8] <= s_if.dat_ms[8*b +: 8];
    end
  end

  // ---------------- helpers ----------------
  int n_vec;
  int n_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic midcyc();
    @(negedge clk);
  endtask

  task automatic drive(input int m, input logic cyc, input logic stb, input logic we,
                       input logic [31:0] adr, input logic [3:0] sel,
                       input logic [31:0] dat, input logic [2:0] cti);
    if (m == 0) begin
      m0_if.cyc = cyc; m0_if.stb = stb; m0_if.we = we; m0_if.adr = adr;
      m0_if.sel = sel; m0_if.dat_ms = dat; m0_if.cti = cti; m0_if.bte = 2'b00;
    end else begin
      m1_if.cyc = cyc; m1_if.stb = stb; m1_if.we = we; m1_if.adr = adr;
      m1_if.sel = sel; m1_if.dat_ms = dat; m1_if.cti = cti; m1_if.bte = 2'b00;
    end
  endtask

  function automatic logic m_ack(input int m);
    return (m == 0) ? m0_if.ack : m1_if.ack;
  endfunction

  function automatic logic [31:0] m_dat(input int m);
    return (m == 0) ? m0_if.dat_sm : m1_if.dat_sm;
  endfunction

  // waits (bounded) for the ack of an already-driven access, then releases cyc
  task automatic wait_ack(input int m, output logic [31:0] rd);
    int n;
    n = 0;
    midcyc();
    while (!m_ack(m) && n < 40) begin
      step();
      midcyc();
      n++;
    end
    check("xfer_ack", 32'(m_ack(m)), 32'd1);
    rd = m_dat(m);
    step();
    drive(m, 0, 0, 0, '0, '0, '0, CTI_CLASSIC);
    step();
  endtask

  task automatic xfer(input int m, input logic we, input logic [31:0] adr,
                      input logic [3:0] sel, input logic [31:0] wd, output logic [31:0] rd);
    drive(m, 1, 1, we, adr, sel, wd, CTI_CLASSIC);
    wait_ack(m, rd);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  // ---------------- directed sequence ----------------
  logic [31:0] rd;
  int          base_wr, beat, first_k, last_k, first_err, err_cnt, ack_cnt, ack_k;
  logic        stb_at, stb17, acked;

  initial begin
    n_vec = 0; n_err = 0; n_swr = 0;
    wdelay = 8'd0;
    rst = 1'b0;
    drive(0, 0, 0, 0, '0, '0, '0, CTI_CLASSIC);
    drive(1, 0, 0, 0, '0, '0, '0, CTI_CLASSIC);

    // reset state
    midcyc();
    check("rst_s_cyc", 32'(s_if.cyc), 32'd0);
    check("rst_s_stb", 32'(s_if.stb), 32'd0);
    check("rst_s_adr", s_if.adr, 32'd0);
    check("rst_m0_ack", 32'(m0_if.ack), 32'd0);
    check("rst_m1_err", 32'(m1_if.err), 32'd0);
    step();
    rst = 1'b1;

    // single write then read-back by m0
    base_wr = n_swr;
    drive(0, 1, 1, 1, 32'h10, 4'hF, 32'hDEADBEEF, CTI_CLASSIC);
    midcyc();
    check("t1_latency_stb", 32'(s_if.stb), 32'd0);
    step();
    midcyc();
    check("t1_s_stb", 32'(s_if.stb), 32'd1);
    check("t1_s_adr", s_if.adr, 32'h10);
    check("t1_s_dat", s_if.dat_ms, 32'hDEADBEEF);
    check("t1_s_sel", 32'(s_if.sel), 32'hF);
    check("t1_m0_ack", 32'(m0_if.ack), 32'd1);
    check("t1_m1_ack", 32'(m1_if.ack), 32'd0);
    step();
    drive(0, 0, 0, 0, '0, '0, '0, CTI_CLASSIC);
    midcyc();
    check("t1_ack_one_cycle", 32'(m0_if.ack), 32'd0);
    check("t1_one_write", 32'(n_swr - base_wr), 32'd1);
    step();
    xfer(0, 1'b0, 32'h10, 4'hF, '0, rd);
    check("t1_readback", rd, 32'hDEADBEEF);

    // collision from reset, handover, round robin
    do_reset();
    drive(0, 1, 1, 1, 32'h40, 4'hF, 32'h1, CTI_CLASSIC);
    drive(1, 1, 1, 1, 32'h44, 4'hF, 32'h2, CTI_CLASSIC);
    midcyc();
    check("t2_idle_cyc", 32'(s_if.cyc), 32'd0);
    step();
    midcyc();
    check("t2_gnt0_adr", s_if.adr, 32'h40);
    check("t2_m1_wait", 32'(m1_if.ack), 32'd0);
    step();
    drive(0, 0, 0, 0, '0, '0, '0, CTI_CLASSIC);
    midcyc();
    check("t2_drop_m1_ack", 32'(m1_if.ack), 32'd0);
    step();
    midcyc();
    check("t2_gnt1_adr", s_if.adr, 32'h44);
    check("t2_m1_ack", 32'(m1_if.ack), 32'd1);
    check("t2_m0_noack", 32'(m0_if.ack), 32'd0);
    step();
    drive(1, 0, 0, 0, '0, '0, '0, CTI_CLASSIC);
    step();
    drive(0, 1, 1, 1, 32'h40, 4'hF, 32'h1, CTI_CLASSIC);
    drive(1, 1, 1, 1, 32'h44, 4'hF, 32'h2, CTI_CLASSIC);
    step();
    midcyc();
    check("t2_rr_gnt0", s_if.adr, 32'h40);
    step();
    drive(0, 0, 0, 0, '0, '0, '0, CTI_CLASSIC);
    drive(1, 0, 0, 0, '0, '0, '0, CTI_CLASSIC);
    step();
    drive(0, 1, 1, 1, 32'h40, 4'hF, 32'h1, CTI_CLASSIC);
    drive(1, 1, 1, 1, 32'h44, 4'hF, 32'h2, CTI_CLASSIC);
    step();
    midcyc();
    check("t2_fair_gnt1", s_if.adr, 32'h44);
    step();
    drive(0, 0, 0, 0, '0, '0, '0, CTI_CLASSIC);
    drive(1, 0, 0, 0, '0, '0, '0, CTI_CLASSIC);
    step();

    // m0 4-beat incrementing burst, m1 requests mid-burst
    for (int i = 0; i < 4; i++) xfer(0, 1'b1, 32'h20 + 32'(4 * i), 4'hF, 32'hB000_0000 + 32'(i), rd);
    drive(0, 1, 1, 0, 32'h20, 4'hF, '0, CTI_INCR);
    beat = 0; first_k = -1; last_k = -1;
    for (int k = 0; k < 20 && beat < 4; k++) begin
      midcyc();
      acked = m0_if.ack;
      if (acked) begin
        check("t3_beat_dat", m0_if.dat_sm, 32'hB000_0000 + 32'(beat));
        check("t3_m1_noack", 32'(m1_if.ack), 32'd0);
        if (first_k < 0) first_k = k;
        last_k = k;
        beat++;
      end
      step();
      if (acked) begin
        if (beat == 1) drive(1, 1, 1, 0, 32'h24, 4'hF, '0, CTI_CLASSIC);
        if (beat == 4) drive(0, 0, 0, 0, '0, '0, '0, CTI_CLASSIC);
        else drive(0, 1, 1, 0, 32'h20 + 32'(4 * beat), 4'hF, '0, (beat == 3) ? CTI_END : CTI_INCR);
      end
    end
    check("t3_beats", 32'(beat), 32'd4);
    check("t3_consecutive", 32'(last_k - first_k), 32'd3);
    midcyc();
    check("t3_release_m1_ack", 32'(m1_if.ack), 32'd0);
    step();
    midcyc();
    check("t3_handover_cyc", 32'(s_if.cyc), 32'd1);
    check("t3_handover_adr", s_if.adr, 32'h24);
    step();
    wait_ack(1, rd);
    check("t3_m1_read", rd, 32'hB000_0001);

    // stalled target: watchdog err
    wdelay = 8'hFF;
    drive(0, 1, 1, 1, 32'h50, 4'hF, 32'h5555, CTI_CLASSIC);
    first_err = -1; err_cnt = 0; ack_cnt = 0; stb_at = 1'b1; stb17 = 1'b0;
    for (int k = 0; k <= 17; k++) begin
      midcyc();
      if (m0_if.err) begin
        err_cnt++;
        if (first_err < 0) begin first_err = k; stb_at = s_if.stb; end
      end
      if (m0_if.ack) ack_cnt++;
      if (k == 17) stb17 = s_if.stb;
      step();
    end
    drive(0, 0, 0, 0, '0, '0, '0, CTI_CLASSIC);
    step();
    check("t4_err_cycle", 32'(first_err), 32'd16);
    check("t4_err_pulses", 32'(err_cnt), 32'd1);
    check("t4_stb_at_err", 32'(stb_at), 32'd0);
    check("t4_stb_after_err", 32'(stb17), 32'd1);
    check("t4_no_ack", 32'(ack_cnt), 32'd0);

    // ack coinciding with expiry wins
    wdelay = 8'd15;
    drive(0, 1, 1, 1, 32'h54, 4'hF, 32'h7777, CTI_CLASSIC);
    err_cnt = 0; ack_k = -1;
    for (int k = 0; k <= 20; k++) begin
      midcyc();
      if (m0_if.err) err_cnt++;
      acked = m0_if.ack;
      if (acked && ack_k < 0) ack_k = k;
      step();
      if (acked) drive(0, 0, 0, 0, '0, '0, '0, CTI_CLASSIC);
    end
    wdelay = 8'd0;
    check("t4b_ack_cycle", 32'(ack_k), 32'd16);
    check("t4b_no_err", 32'(err_cnt), 32'd0);

    // async reset during beat 2 of an m1 burst
    drive(1, 1, 1, 0, 32'h20, 4'hF, '0, CTI_INCR);
    step();
    step();
    midcyc();
    check("t5_beat1", 32'(m1_if.ack), 32'd1);
    step();
    drive(1, 1, 1, 0, 32'h24, 4'hF, '0, CTI_INCR);
    midcyc();
    check("t5_beat2", 32'(m1_if.ack), 32'd1);
    #1 rst = 1'b0;
    #1;
    check("t5_async_cyc", 32'(s_if.cyc), 32'd0);
    check("t5_async_stb", 32'(s_if.stb), 32'd0);
    check("t5_async_ack", 32'(m1_if.ack), 32'd0);
    check("t5_async_err", 32'(m1_if.err), 32'd0);
    drive(1, 0, 0, 0, '0, '0, '0, CTI_CLASSIC);
    step();
    step();
    rst = 1'b1;
    drive(0, 1, 1, 1, 32'h60, 4'hF, 32'h3, CTI_CLASSIC);
    drive(1, 1, 1, 1, 32'h64, 4'hF, 32'h4, CTI_CLASSIC);
    midcyc();
    check("t5_idle_cyc", 32'(s_if.cyc), 32'd0);
    step();
    midcyc();
    check("t5_gnt0_adr", s_if.adr, 32'h60);
    check("t5_gnt0_ack", 32'(m0_if.ack), 32'd1);
    step();
    drive(0, 0, 0, 0, '0, '0, '0, CTI_CLASSIC);
    drive(1, 0, 0, 0, '0, '0, '0, CTI_CLASSIC);
    step();
    step();

    // byte-lane write merge
    xfer(0, 1'b1, 32'h30, 4'hF, 32'h1122_3344, rd);
    xfer(0, 1'b1, 32'h30, 4'b0100, 32'h00AB_0000, rd);
    xfer(1, 1'b0, 32'h30, 4'hF, '0, rd);
    check("t6_byte_merge", rd, 32'h11AB_3344);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
